// File: rtl/sprite_color_mapper.sv
// Pac-Man pixel colour generator: maze flags + Pac-Man + NUM_GHOSTS ghosts -> 24-bit RGB.
// Latency: 2 cycles from pixel inputs to VGA_R/G/B and out_valid, 1 pixel per cycle.
// Backpressure: none; the pixel stream is free-running and every input cycle produces one output.
//
// Ports: Clk/Reset_n (async active-low); frame_start pulse advances the frame-synchronous
// animation state; pixel_valid/DrawX/DrawY plus is_wall/is_pellet describe the current pixel;
// pacman_* and ghost_* place the sprites; fright_start (re)loads frightened mode.
// Outputs: out_valid, VGA_R/G/B (registered), fright_active (combinational from the counter).
// Optional macro SPRITE_BLINK_EN: frightened ghosts blink white/blue during the last
// BLINK_FRAMES frames of fright.
module sprite_color_mapper #(
  parameter int NUM_GHOSTS    = 4,
  parameter int TILE_BITS     = 4,
  parameter int ANIM_FRAMES   = 8,
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic                    pixel_valid,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    is_wall,
  input  logic                    is_pellet,
  input  logic [9:0]              pacman_x,
  input  logic [9:0]              pacman_y,
  input  logic [1:0]              pacman_dir,
  input  logic [10*NUM_GHOSTS-1:0] ghost_x,
  input  logic [10*NUM_GHOSTS-1:0] ghost_y,
  input  logic [NUM_GHOSTS-1:0]   ghost_alive,
  input  logic                    fright_start,
  output logic                    out_valid,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    fright_active
);

  localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_FRAMES - 1);
  localparam logic [11:0] FRIGHT_LOAD = 12'(FRIGHT_FRAMES);
  localparam int T = 1 << TILE_BITS;
  // Pellet occupies the open interval (T/2-3, T/2+2) of the tile, i.e. [T/2-2, T/2+1].
  localparam logic [TILE_BITS-1:0] PEL_LO = TILE_BITS'(T/2 - 2);
  localparam logic [TILE_BITS-1:0] PEL_HI = TILE_BITS'(T/2 + 1);

  localparam logic [23:0] COL_PAC    = 24'hFFFF00;
  localparam logic [23:0] COL_FRIGHT = 24'h2121FF;
  localparam logic [23:0] COL_PELLET = 24'hFFFFFF;
  localparam logic [23:0] COL_WALL   = 24'h1919A6;

  generate
    if (NUM_GHOSTS < 1 || NUM_GHOSTS > 8 || ANIM_FRAMES < 1 ||
        FRIGHT_FRAMES >= 4096 || BLINK_FRAMES > FRIGHT_FRAMES) begin : g_bad_params
      $error("sprite_color_mapper: illegal parameter set");
    end
  endgenerate

  function automatic logic [23:0] ghost_palette(input int k);
    case (k % 4)
      0:       return 24'hFF0000;
      1:       return 24'hFFB8FF;
      2:       return 24'h00FFFF;
      default: return 24'hFFB852;
    endcase
  endfunction

  // ---------------- frame-synchronous state ----------------
  logic [AW-1:0] anim_q, anim_d;
  logic          mouth_open_q, mouth_open_d;
  logic [11:0]   fcnt_q, fcnt_d;
  logic          disp_fright_q, disp_fright_d;
  logic [23:0]   ghost_fr_col;

`ifdef SPRITE_BLINK_EN
  localparam logic [11:0] BLINK_LIM = 12'(BLINK_FRAMES);
  logic [3:0]  fctr_q, fctr_d;   // free-running frame counter, bit 3 sets the blink phase
  logic [11:0] dcnt_q, dcnt_d;   // counter value latched alongside disp_fright
`endif

  always_comb begin
    anim_d        = anim_q;
    mouth_open_d  = mouth_open_q;
    fcnt_d        = fcnt_q;
    disp_fright_d = disp_fright_q;
`ifdef SPRITE_BLINK_EN
    fctr_d        = fctr_q;
    dcnt_d        = dcnt_q;
`endif
    if (frame_start) begin
      if (anim_q == ANIM_LAST) begin
        anim_d       = '0;
        mouth_open_d = ~mouth_open_q;
      end else begin
        anim_d = anim_q + AW'(1);
      end
    end
    // A load beats a same-cycle decrement.
    if (fright_start) begin
      fcnt_d = FRIGHT_LOAD;
    end else if (frame_start && fcnt_q != 12'd0) begin
      fcnt_d = fcnt_q - 12'd1;
    end
    // Displayed state follows the post-update counter, but only at frame boundaries.
    if (frame_start) begin
      disp_fright_d = (fcnt_d != 12'd0);
`ifdef SPRITE_BLINK_EN
      fctr_d = fctr_q + 4'd1;
      dcnt_d = fcnt_d;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      anim_q        <= '0;
      mouth_open_q  <= 1'b0;
      fcnt_q        <= 12'd0;
      disp_fright_q <= 1'b0;
`ifdef SPRITE_BLINK_EN
      fctr_q        <= 4'd0;
      dcnt_q        <= 12'd0;
`endif
    end else begin
      anim_q        <= anim_d;
      mouth_open_q  <= mouth_open_d;
      fcnt_q        <= fcnt_d;
      disp_fright_q <= disp_fright_d;
`ifdef SPRITE_BLINK_EN
      fctr_q        <= fctr_d;
      dcnt_q        <= dcnt_d;
`endif
    end
  end

  assign fright_active = (fcnt_q != 12'd0);

`ifdef SPRITE_BLINK_EN
  assign ghost_fr_col = (dcnt_q <= BLINK_LIM && !fctr_q[3]) ? COL_PELLET : COL_FRIGHT;
`else
  assign ghost_fr_col = COL_FRIGHT;
`endif

  // ---------------- stage 1: hit flags ----------------
  // 11-bit coordinates so sprite bounds past x=1023 do not wrap back to the left edge.
  logic [10:0] xi, yi, pxi, pyi;
  assign xi  = {1'b0, DrawX};
  assign yi  = {1'b0, DrawY};
  assign pxi = {1'b0, pacman_x};
  assign pyi = {1'b0, pacman_y};

  logic pac_body;
  assign pac_body = (xi >= pxi + 11'd2) && (xi < pxi + 11'd14) &&
                    (yi >= pyi + 11'd2) && (yi < pyi + 11'd14);

  // Local offsets are only meaningful inside the body, where they fit in 4 bits.
  logic [3:0]        lx, ly;
  logic signed [5:0] dx, dy, ax, ay;
  logic              wedge;
  assign lx = DrawX[3:0] - pacman_x[3:0];
  assign ly = DrawY[3:0] - pacman_y[3:0];
  assign dx = $signed({2'b00, lx}) - 6'sd8;
  assign dy = $signed({2'b00, ly}) - 6'sd8;
  assign ax = dx[5] ? -dx : dx;
  assign ay = dy[5] ? -dy : dy;

  // Mouth wedge: a 90-degree cone opening from the cell centre (8,8) in the facing direction.
  always_comb begin
    wedge = 1'b0;
    case (pacman_dir)
      2'd0:    wedge = !dx[5] && (ay <= dx);
      2'd1:    wedge = (dy <= 6'sd0) && (ax <= -dy);
      2'd2:    wedge = (dx <= 6'sd0) && (ay <= -dx);
      default: wedge = !dy[5] && (ax <= dy);
    endcase
  end

  logic        ghost_hit;
  logic [23:0] ghost_col;
  always_comb begin
    logic [10:0] gxi;
    logic [10:0] gyi;
    ghost_hit = 1'b0;
    ghost_col = 24'h000000;
    gxi       = 11'd0;
    gyi       = 11'd0;
    // Scan high to low so the lowest-indexed overlapping ghost is the last writer.
    for (int k = NUM_GHOSTS - 1; k >= 0; k--) begin
      gxi = {1'b0, ghost_x[10*k +: 10]};
      gyi = {1'b0, ghost_y[10*k +: 10]};
      if (ghost_alive[k] && (xi >= gxi + 11'd1) && (xi < gxi + 11'd15) &&
          (yi >= gyi + 11'd1) && (yi < gyi + 11'd15)) begin
        ghost_hit = 1'b1;
        ghost_col = disp_fright_q ? ghost_fr_col : ghost_palette(k);
      end
    end
  end

  logic pel_hit;
  assign pel_hit = is_pellet &&
                   (DrawX[TILE_BITS-1:0] >= PEL_LO) && (DrawX[TILE_BITS-1:0] <= PEL_HI) &&
                   (DrawY[TILE_BITS-1:0] >= PEL_LO) && (DrawY[TILE_BITS-1:0] <= PEL_HI);

  logic        s1_vld_q, s1_pac_q, s1_ghost_q, s1_pel_q, s1_wall_q;
  logic        s1_pac_d;
  logic [23:0] s1_gcol_q;
  assign s1_pac_d = pac_body && !(mouth_open_q && wedge);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_pac_q   <= 1'b0;
      s1_ghost_q <= 1'b0;
      s1_gcol_q  <= 24'h000000;
      s1_pel_q   <= 1'b0;
      s1_wall_q  <= 1'b0;
    end else begin
      s1_vld_q   <= pixel_valid;
      s1_pac_q   <= s1_pac_d;
      s1_ghost_q <= ghost_hit;
      s1_gcol_q  <= ghost_col;
      s1_pel_q   <= pel_hit;
      s1_wall_q  <= is_wall;
    end
  end

  // ---------------- stage 2: priority mux ----------------
  logic [23:0] rgb_q, rgb_d;
  logic        vld_q;

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_vld_q) begin
      if (s1_pac_q)        rgb_d = COL_PAC;
      else if (s1_ghost_q) rgb_d = s1_gcol_q;
      else if (s1_pel_q)   rgb_d = COL_PELLET;
      else if (s1_wall_q)  rgb_d = COL_WALL;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= 24'h000000;
      vld_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      vld_q <= s1_vld_q;
    end
  end

  assign out_valid = vld_q;
  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed + randomized bench for sprite_color_mapper against a frame/pixel reference model.
// Latency: expected values are delayed two clock edges to match the output pipeline.
// Backpressure: none; one pixel is driven per clock.
module tb_sprite_color_mapper;
  localparam int NG = 4;
  localparam int TB = 4;
  localparam int AF = 2;
  localparam int FF = 20;
  localparam int BF = 16;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b1;
  logic            frame_start = 1'b0;
  logic            pixel_valid = 1'b0;
  logic [9:0]      DrawX = '0, DrawY = '0;
  logic            is_wall = 1'b0, is_pellet = 1'b0;
  logic [9:0]      pacman_x = 10'd500, pacman_y = 10'd500;
  logic [1:0]      pacman_dir = 2'd0;
  logic [10*NG-1:0] ghost_x = '0, ghost_y = '0;
  logic [NG-1:0]   ghost_alive = '0;
  logic            fright_start = 1'b0;
  logic            out_valid, fright_active;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  sprite_color_mapper #(
    .NUM_GHOSTS(NG), .TILE_BITS(TB), .ANIM_FRAMES(AF),
    .FRIGHT_FRAMES(FF), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .is_wall(is_wall), .is_pellet(is_pellet),
    .pacman_x(pacman_x), .pacman_y(pacman_y), .pacman_dir(pacman_dir),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_alive(ghost_alive),
    .fright_start(fright_start), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .fright_active(fright_active)
  );

  always #5 Clk = ~Clk;

  int gx[NG];
  int gy[NG];
  int total = 0;
  int bad = 0;

  // Reference model state: pulses since reset, frame index of last fright load,
  // and the fright state captured at the latest frame pulse.
  int   frames = 0;
  int   load_at = -1;
  int   disp_rem = 0;
  bit   disp_m = 1'b0;
  logic [24:0] e1 = '0, e2 = '0;

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int remaining(input int fr);
    int r;
    if (load_at < 0) return 0;
    r = FF - (fr - load_at);
    return (r > 0) ? r : 0;
  endfunction

  function automatic logic [23:0] fright_colour();
`ifdef SPRITE_BLINK_EN
    if (disp_rem <= BF && ((frames / 8) % 2) == 0) return 24'hFFFFFF;
`endif
    return 24'h2121FF;
  endfunction

  function automatic logic [23:0] ref_pixel();
    int x, y, lx, ly, u, v, tx, ty, t;
    bit open;
    x  = int'(DrawX);
    y  = int'(DrawY);
    lx = x - int'(pacman_x);
    ly = y - int'(pacman_y);
    open = ((frames / AF) % 2) == 1;
    if (lx >= 2 && lx < 14 && ly >= 2 && ly < 14) begin
      // u = distance ahead of the centre in the facing direction, v = sideways offset
      case (pacman_dir)
        2'd0:    begin u = lx - 8; v = ly - 8; end
        2'd1:    begin u = 8 - ly; v = lx - 8; end
        2'd2:    begin u = 8 - lx; v = ly - 8; end
        default: begin u = ly - 8; v = lx - 8; end
      endcase
      if (!(open && u >= 0 && ((v < 0) ? -v : v) <= u)) return 24'hFFFF00;
    end
    for (int k = 0; k < NG; k++) begin
      if (ghost_alive[k] && x - gx[k] >= 1 && x - gx[k] < 15 &&
          y - gy[k] >= 1 && y - gy[k] < 15) begin
        if (disp_m) return fright_colour();
        case (k % 4)
          0:       return 24'hFF0000;
          1:       return 24'hFFB8FF;
          2:       return 24'h00FFFF;
          default: return 24'hFFB852;
        endcase
      end
    end
    t  = 1 << TB;
    tx = x % t;
    ty = y % t;
    if (is_pellet && tx > t/2 - 3 && tx < t/2 + 2 && ty > t/2 - 3 && ty < t/2 + 2)
      return 24'hFFFFFF;
    if (is_wall) return 24'h1919A6;
    return 24'h000000;
  endfunction

  task automatic tick();
    logic [24:0] ne;
    bit fs, fr;
    for (int k = 0; k < NG; k++) begin
      ghost_x[10*k +: 10] = 10'(gx[k]);
      ghost_y[10*k +: 10] = 10'(gy[k]);
    end
    #0;
    ne = pixel_valid ? {1'b1, ref_pixel()} : 25'd0;
    fs = frame_start;
    fr = fright_start;
    @(posedge Clk);
    #1;
    e2 = e1;
    e1 = ne;
    if (fs) frames++;
    if (fr) load_at = frames;
    if (fs) begin
      disp_rem = remaining(frames);
      disp_m   = disp_rem > 0;
    end
    chk("pipe", {out_valid, VGA_R, VGA_G, VGA_B}, e2);
    chk("fright_active", {24'd0, fright_active}, {24'd0, remaining(frames) > 0});
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    chk("rst_rgb", {out_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    chk("rst_fa", {24'd0, fright_active}, 25'd0);
    frames = 0; load_at = -1; disp_rem = 0; disp_m = 1'b0; e1 = '0; e2 = '0;
    @(posedge Clk);
    #1;
    chk("rst_hold", {out_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    Reset_n = 1'b1;
  endtask

  initial begin
    int base;
    for (int k = 0; k < NG; k++) begin gx[k] = 600; gy[k] = 600; end
    #2;
    do_reset();

    // Overlap priority: Pac-Man over ghosts over wall; ghost0 beats ghost1.
    pacman_x = 10'd100; pacman_y = 10'd100; pacman_dir = 2'd0;
    gx[0] = 104; gy[0] = 100; gx[1] = 104; gy[1] = 100; ghost_alive = 4'b0011;
    is_wall = 1'b1; DrawX = 10'd106; DrawY = 10'd106; pixel_valid = 1'b1;
    tick();
    chk("lat_not_yet", {out_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    tick();
    chk("overlap_pac", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFF00});
    DrawX = 10'd116;
    settle();
    chk("overlap_ghost0", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFF0000});

    // Mouth animation at lx=12, ly=8 facing right.
    ghost_alive = '0; is_wall = 1'b0; DrawX = 10'd112; DrawY = 10'd108;
    settle();
    chk("mouth_f0", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFF00});
    pulse(); settle();
    chk("mouth_f1", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFF00});
    pulse(); settle();
    chk("mouth_f2", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h000000});
    pulse(); settle();
    chk("mouth_f3", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h000000});
    pulse(); settle();
    chk("mouth_f4", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFF00});

    // Fright timing: mid-frame load, colour change at next frame, expiry after FF pulses.
    pacman_x = 10'd500; pacman_y = 10'd500;
    gx[0] = 200; gy[0] = 200; ghost_alive = 4'b0001; DrawX = 10'd205; DrawY = 10'd205;
    fright_start = 1'b1; tick(); fright_start = 1'b0;
    chk("fa_after_load", {24'd0, fright_active}, {24'd0, 1'b1});
    settle();
    chk("ghost_midframe", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFF0000});
    pulse(); settle();
    chk("ghost_fright", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h2121FF});
    for (int i = 0; i < FF - 2; i++) pulse();
    chk("fa_before_expiry", {24'd0, fright_active}, {24'd0, 1'b1});
    pulse();
    chk("fa_expired", {24'd0, fright_active}, 25'd0);
    settle();
    chk("ghost_after_fright", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFF0000});

    // Simultaneous load + frame pulse reloads without a decrement.
    fright_start = 1'b1; tick(); fright_start = 1'b0;
    for (int i = 0; i < 5; i++) pulse();
    frame_start = 1'b1; fright_start = 1'b1; tick();
    frame_start = 1'b0; fright_start = 1'b0;
    for (int i = 0; i < FF - 1; i++) pulse();
    chk("reload_no_dec", {24'd0, fright_active}, {24'd0, 1'b1});
    pulse();
    chk("reload_expire", {24'd0, fright_active}, 25'd0);

    // Sprites at the right edge must not wrap onto x=3.
    pacman_x = 10'd1020; pacman_y = 10'd0; pacman_dir = 2'd0;
    gx[0] = 1020; gy[0] = 0; ghost_alive = 4'b0001; DrawX = 10'd3; DrawY = 10'd5;
    settle();
    chk("edge_nowrap", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h000000});

    // Pellet window 6..9 inside a 16-pixel tile.
    pacman_x = 10'd500; pacman_y = 10'd500; ghost_alive = '0;
    is_pellet = 1'b1; DrawX = 10'd22; DrawY = 10'd7;
    settle();
    chk("pellet_in", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFFFF});
    DrawX = 10'd21;
    settle();
    chk("pellet_out", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h000000});

    // Invalid pixel is black and flagged invalid even over a wall.
    is_pellet = 1'b0; is_wall = 1'b1; pixel_valid = 1'b0;
    settle();
    chk("invalid_px", {out_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    is_wall = 1'b0;

    // Reset mid-stream with fright active, then check 2-cycle latency again.
    pacman_x = 10'd100; pacman_y = 10'd100; DrawX = 10'd106; DrawY = 10'd106;
    pixel_valid = 1'b1;
    fright_start = 1'b1; tick(); fright_start = 1'b0;
    settle();
    do_reset();
    tick();
    chk("post_rst_lat", {out_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    tick();
    chk("post_rst_first", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFF00});

    // Randomized stream: sprites clustered so overlaps are frequent, some epochs at the x edge.
    base = 295;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        base = ((c / 64) % 2 == 1) ? 1000 : 295;
        pacman_x   = 10'((base + int'($urandom_range(0, 20))) % 1024);
        pacman_y   = 10'(295 + $urandom_range(0, 20));
        pacman_dir = 2'($urandom_range(0, 3));
        for (int k = 0; k < NG; k++) begin
          gx[k] = (base + int'($urandom_range(0, 30))) % 1024;
          gy[k] = 295 + int'($urandom_range(0, 30));
        end
        ghost_alive = 4'($urandom_range(0, 15));
      end
      DrawX        = 10'((base + int'($urandom_range(0, 45))) % 1024);
      DrawY        = 10'(292 + $urandom_range(0, 45));
      is_wall      = 1'($urandom_range(0, 1));
      is_pellet    = 1'($urandom_range(0, 1));
      pixel_valid  = ($urandom_range(0, 9) != 0);
      frame_start  = ($urandom_range(0, 15) == 0);
      fright_start = ($urandom_range(0, 399) == 0);
      tick();
    end
    frame_start = 1'b0;
    fright_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_color_mapper.md
# sprite_color_mapper

Pipelined, parametrised pixel colour generator for the Pac-Man VGA path: decides the 24-bit colour of every pixel from maze flags, one Pac-Man sprite and `NUM_GHOSTS` ghost sprites. It adds frame-synchronous animation: a Pac-Man mouth chomp, a frightened-ghost timer and an optional end-of-fright blink. It sits between the maze/pellet lookup and the VGA DAC. Its output is registered with a fixed 2-cycle latency, which the VGA controller compensates for by delaying sync by 2 cycles.

## Interface
- `NUM_GHOSTS`, 4, number of ghost sprite channels (1..8)
- `TILE_BITS`, 4, log2 of the maze tile edge in pixels
- `ANIM_FRAMES`, 8, frames per mouth phase (open/closed), ≥1
- `FRIGHT_FRAMES`, 360, frightened duration in frames, < 2^12
- `BLINK_FRAMES`, 120, final fright frames that blink, ≤ FRIGHT_FRAMES

- `Clk`  in  1  pixel clock
- `Reset_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse at the start of each frame (vsync edge)
- `pixel_valid`  in  1  `DrawX`/`DrawY` lie in the active area
- `DrawX`, `DrawY`  in  10 each  current pixel coordinates
- `is_wall`, `is_pellet`  in  1 each  maze flags for the current tile
- `pacman_x`, `pacman_y`  in  10 each  top-left corner of the Pac-Man 16×16 cell
- `pacman_dir`  in  2  facing direction: 0=right, 1=up, 2=left, 3=down
- `ghost_x`, `ghost_y`  in  10*NUM_GHOSTS each  ghost k at bits [10k+9:10k]
- `ghost_alive`  in  NUM_GHOSTS  ghost k is drawn
- `fright_start`  in  1  pulse: start or restart frightened mode
- `out_valid`  out  1  the RGB on this cycle belongs to a valid pixel
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  colour
- `fright_active`  out  1  fright counter is nonzero

## Operation
- **Stage 1** registers the pixel inputs and computes hit flags. **Stage 2** applies the priority mux and registers the RGB.
- **Priority:** Pac-Man > ghost (lowest index wins) > pellet > wall > black.
- **Pac-Man body:**
  - The body is the pixels with local `lx=DrawX-pacman_x` and `ly=DrawY-pacman_y` both in [2,14). Colour FFFF00.
  - When the mouth phase is open, the wedge pixels show what lies underneath instead. For right-facing, the wedge is `lx≥8` with `|ly-8| ≤ lx-8`. The other directions are the same wedge rotated.
- **Ghost k:**
  - The ghost is the pixels with local offsets in [1,15) on both axes, drawn only if `ghost_alive[k]`.
  - Normal palette by `k mod 4`: FF0000, FFB8FF, 00FFFF, FFB852.
  - While displayed-frightened, the colour is 2121FF.
- **Pellet:** both `DrawX[TILE_BITS-1:0]` and `DrawY[TILE_BITS-1:0]` in (T/2-3, T/2+2), where T=2^TILE_BITS. For T=16 this is 6..9.
- **Wall:** 1919A6.
- **Arithmetic:** all sprite bounds are computed at 11 bits, so a sprite near x=1023 never wraps.
- **Invalid pixels:** when `pixel_valid`=0, the output is 000000 and `out_valid`=0 two cycles later.
- **Mouth animation:**
  - `anim_cnt` counts `frame_start` pulses from 0 to ANIM_FRAMES-1 and then wraps.
  - The mouth phase toggles on the wrap.
- **Fright counter:**
  - `fright_start` loads FRIGHT_FRAMES, and also reloads it if already active.
  - Each `frame_start` decrements the counter when it is nonzero. The counter saturates at 0.
  - If `fright_start` and `frame_start` arrive in the same cycle, the load wins and there is no decrement.
- **Displayed fright state:**
  - `disp_fright` is latched from the counter only on `frame_start`, so colours never change mid-frame.
  - `fright_active` is combinational from the counter and updates immediately.

## Timing
- **Latency:** pixel inputs at cycle n appear on RGB/`out_valid` at cycle n+2, with a throughput of 1 pixel per cycle.
- **Frame-state updates:** a `frame_start` at cycle n updates `anim_cnt`, the mouth phase, the fright counter and `disp_fright` at the n+1 edge. Pixels sampled from cycle n+1 onward use the new state.
- **Reset values** (asynchronous, on `Reset_n`=0):
  - Pipeline registers are 0, so RGB=000000 and `out_valid`=0.
  - `anim_cnt`=0, mouth closed, fright counter=0, `disp_fright`=0.
  - Hence `fright_active`=0.
- **Reset released mid-frame:** the first two outputs are black/invalid. Animation starts at the next `frame_start`.

## Configuration
- **`SPRITE_BLINK_EN` defined:**
  - While `disp_fright`=1 and the latched counter is ≤ BLINK_FRAMES, frightened ghosts alternate every 8 frames, using bit 3 of a free-running frame counter.
  - The two colours are 2121FF and FFFFFF, starting with FFFFFF.
- **`SPRITE_BLINK_EN` undefined:** frightened ghosts stay 2121FF for the whole duration, and no blink logic is built.

## Test plan
- **Reset:** hold `Reset_n`=0 mid-stream → RGB=000000 and `out_valid`=0 immediately. After release, the first valid colour appears exactly 2 cycles after `pixel_valid`.
- **Overlap priority:** pacman=(100,100), ghost0=(104,100), ghost1=(104,100), `is_wall`=1, pixel (106,106) with the mouth closed → FFFF00. Pixel (116,106) → FF0000, where ghost0 beats ghost1.
- **Mouth animation:** ANIM_FRAMES=2, dir=right. Pixel lx=12, ly=8 is FFFF00 for frames 0–1, then shows the underlying colour (e.g. black) for frames 2–3, then FFFF00 again.
- **Fright timing:** `fright_start` mid-frame leaves ghosts in their normal colour until the next `frame_start`, then 2121FF. Exactly FRIGHT_FRAMES `frame_start` pulses after the load, `fright_active`→0. A simultaneous `fright_start`+`frame_start` reloads without a decrement.
- **Edge sprite and pellet:** pacman_x=1020 with DrawX=3 → no Pac-Man hit (no wrap). A pellet tile at DrawX=16+6, DrawY=7 → FFFFFF, and at DrawX=16+5 → 000000.
- **Blink (`SPRITE_BLINK_EN`):** FRIGHT_FRAMES=20, BLINK_FRAMES=16. Ghost colour changes between 2121FF and FFFFFF at 8-frame boundaries only while the counter is ≤16. Without the macro it is constant 2121FF.
